pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. It merges the hazard unit's combinational requests (stall, flush, bubble mux, branch resolve) with I-cache and D-cache miss stalls. It produces per-stage register enables, IF/ID flush, ID/EX bubble insertion and PC redirect selection. It owns the only sequential redirect state: a branch resolved during an I-cache miss is latched and applied after the wrong-path fetch returns and is discarded.

---
 rtl/pipeline_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges hazard and cache-miss
// stalls into stage enables, flushes, bubbles and PC redirect, holding a deferred redirect.
module pipeline_stall_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_stall,
    input  logic              hazard_flush,
    input  logic              hazard_mux,
    input  logic              branch_flag,
    input  logic [XLEN-1:0]   branch_target,
    input  logic              icache_stall,
    input  logic              dcache_stall,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              ex_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pc_sel,
    output logic [XLEN-1:0]   pc_redirect,
    output logic              redirect_pending,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_WAIT_I = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [XLEN-1:0]    pend_target_r;
    logic [XLEN-1:0]    pend_target_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;

    logic               pc_en_s;
    logic               if_id_en_s;
    logic               ex_en_s;
    logic               if_id_flush_s;
    logic               id_ex_bubble_s;
    logic               pc_sel_s;
    logic [XLEN-1:0]    pc_redirect_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state and combinational stage control, highest priority first.
    always_comb begin
        pc_en_s           = 1'b0;
        if_id_en_s        = 1'b0;
        ex_en_s           = 1'b0;
        if_id_flush_s     = 1'b0;
        id_ex_bubble_s    = 1'b0;
        pc_sel_s          = 1'b0;
        state_nxt_s       = state_r;
        pend_target_nxt_s = pend_target_r;
        pc_redirect_s     = (state_r == ST_WAIT_I) ? pend_target_r : branch_target;

        if (rst) begin
            pc_redirect_s = {XLEN{1'b0}};
        end else if (dcache_stall) begin
            // Whole pipe frozen; branch/hazard inputs are re-evaluated once MEM completes.
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hazard_stall) begin
                        ex_en_s        = 1'b1;
                        id_ex_bubble_s = hazard_mux;
                    end else if (icache_stall) begin
                        if_id_en_s    = 1'b1;
                        if_id_flush_s = 1'b1;
                        ex_en_s       = 1'b1;
                        if (branch_flag) begin
                            // Redirect must wait until the in-flight wrong-path fetch returns.
                            pend_target_nxt_s = branch_target;
                            state_nxt_s       = ST_WAIT_I;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else if (branch_flag) begin
                        pc_en_s       = 1'b1;
                        if_id_en_s    = 1'b1;
                        ex_en_s       = 1'b1;
                        if_id_flush_s = 1'b1;
                        pc_sel_s      = 1'b1;
                    end else begin
                        pc_en_s       = 1'b1;
                        if_id_en_s    = 1'b1;
                        ex_en_s       = 1'b1;
                        if_id_flush_s = hazard_flush;
                    end
                end
                ST_WAIT_I: begin
                    if_id_en_s    = 1'b1;
                    if_id_flush_s = 1'b1;
                    ex_en_s       = 1'b1;
                    if (icache_stall) begin
                        state_nxt_s = ST_WAIT_I;
                    end else begin
                        pc_en_s     = 1'b1;
                        pc_sel_s    = 1'b1;
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State and deferred redirect target register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            pend_target_r <= {XLEN{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            pend_target_r <= pend_target_nxt_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_en_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (if_id_flush_s && if_id_en_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign pc_en            = pc_en_s;
    assign if_id_en         = if_id_en_s;
    assign ex_en            = ex_en_s;
    assign if_id_flush      = if_id_flush_s;
    assign id_ex_bubble     = id_ex_bubble_s;
    assign pc_sel           = pc_sel_s;
    assign pc_redirect      = pc_redirect_s;
    assign redirect_pending = !rst && (state_r == ST_WAIT_I);
    assign stall_cnt        = stall_cnt_r;
    assign flush_cnt        = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized and directed bench for pipeline_stall_ctrl against a behavioural model
// of the pipeline control rules; two instances cover 16-bit and 4-bit counters.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst, hs, hf, hm, br, ic, dc;
    logic [31:0] bt;

    logic        pc_en, if_id_en, ex_en, if_id_flush, id_ex_bubble, pc_sel, redirect_pending;
    logic [31:0] pc_redirect;
    logic [15:0] stall_cnt, flush_cnt;

    logic        a_pc_en, a_if_id_en, a_ex_en, a_if_id_flush, a_id_ex_bubble, a_pc_sel, a_pend;
    logic [31:0] a_pc_redirect;
    logic [3:0]  a_stall_cnt, a_flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model: is a redirect deferred, to where, and raw event counts since reset.
    bit          m_pend;
    logic [31:0] m_tgt;
    int          m_sc, m_fc;
    logic [6:0]  last_ctrl;
    logic [31:0] last_red;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hs), .hazard_flush(hf), .hazard_mux(hm),
        .branch_flag(br), .branch_target(bt), .icache_stall(ic), .dcache_stall(dc),
        .pc_en(pc_en), .if_id_en(if_id_en), .ex_en(ex_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pc_sel(pc_sel), .pc_redirect(pc_redirect),
        .redirect_pending(redirect_pending), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_stall_ctrl #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .hazard_stall(hs), .hazard_flush(hf), .hazard_mux(hm),
        .branch_flag(br), .branch_target(bt), .icache_stall(ic), .dcache_stall(dc),
        .pc_en(a_pc_en), .if_id_en(a_if_id_en), .ex_en(a_ex_en), .if_id_flush(a_if_id_flush),
        .id_ex_bubble(a_id_ex_bubble), .pc_sel(a_pc_sel), .pc_redirect(a_pc_redirect),
        .redirect_pending(a_pend), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model on the edge.
    task automatic step(input bit r, input bit s, input bit f, input bit m, input bit b,
                        input logic [31:0] t, input bit i, input bit d);
        bit          e_pc, e_ifid, e_ex, e_fl, e_bub, e_sel, n_pend;
        logic [31:0] e_red, n_tgt;
        logic [6:0]  e_ctrl, a_ctrl;
        rst = r; hs = s; hf = f; hm = m; br = b; bt = t; ic = i; dc = d;
        #3;
        {e_pc, e_ifid, e_ex, e_fl, e_bub, e_sel} = 6'b000000;
        n_pend = m_pend;
        n_tgt  = m_tgt;
        e_red  = m_pend ? m_tgt : t;
        if (r) begin
            e_red = 32'h0; n_pend = 1'b0; n_tgt = 32'h0;
        end else if (d) begin
            e_pc = 1'b0;
        end else if (m_pend) begin
            e_ifid = 1'b1; e_fl = 1'b1; e_ex = 1'b1;
            if (!i) begin
                e_pc = 1'b1; e_sel = 1'b1; n_pend = 1'b0;
            end
        end else if (s) begin
            e_ex = 1'b1; e_bub = m;
        end else if (i) begin
            e_ifid = 1'b1; e_fl = 1'b1; e_ex = 1'b1;
            if (b) begin
                n_pend = 1'b1; n_tgt = t;
            end
        end else begin
            e_pc = 1'b1; e_ifid = 1'b1; e_ex = 1'b1; e_fl = b | f; e_sel = b;
        end
        e_ctrl    = {e_pc, e_ifid, e_ex, e_fl, e_bub, e_sel, (!r && m_pend)};
        last_ctrl = {pc_en, if_id_en, ex_en, if_id_flush, id_ex_bubble, pc_sel, redirect_pending};
        last_red  = pc_redirect;
        a_ctrl    = {a_pc_en, a_if_id_en, a_ex_en, a_if_id_flush, a_id_ex_bubble, a_pc_sel, a_pend};
        chk("ctrl", 64'(last_ctrl), 64'(e_ctrl));
        chk("ctrl4", 64'(a_ctrl), 64'(e_ctrl));
        chk("redirect", 64'(last_red), 64'(e_red));
        chk("stall_cnt", 64'(stall_cnt), 64'(sat(m_sc, 65535)));
        chk("flush_cnt", 64'(flush_cnt), 64'(sat(m_fc, 65535)));
        chk("stall_cnt4", 64'(a_stall_cnt), 64'(sat(m_sc, 15)));
        chk("flush_cnt4", 64'(a_flush_cnt), 64'(sat(m_fc, 15)));
        if (r) begin
            m_sc = 0; m_fc = 0;
        end else begin
            if (!e_pc) m_sc++;
            if (e_fl && e_ifid) m_fc++;
        end
        m_pend = n_pend;
        m_tgt  = n_tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit i, input bit d);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, i, d);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; hf = 1'b0; hm = 1'b0; br = 1'b0; bt = 32'h0; ic = 1'b0; dc = 1'b0;
        m_pend = 1'b0; m_tgt = 32'h0; m_sc = 0; m_fc = 0;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_ctrl", 64'(last_ctrl), 64'(7'b0000000));

        // Load-use stall with bubble
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("lu_ctrl", 64'(last_ctrl), 64'(7'b0010100));
        idle(1'b0, 1'b0);
        chk("lu_next", 64'(last_ctrl), 64'(7'b1110000));
        chk("lu_cnt", 64'(stall_cnt), 64'(16'd1));

        // Branch in RUN
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0120, 1'b0, 1'b0);
        chk("br_ctrl", 64'(last_ctrl), 64'(7'b1111010));
        chk("br_tgt", 64'(last_red), 64'(32'h120));
        chk("br_fcnt", 64'(flush_cnt), 64'(16'd1));

        // Branch on I-miss cycle 2 of 5
        do_reset();
        idle(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        chk("im_c2", 64'(last_ctrl), 64'(7'b0111000));
        for (int k = 0; k < 3; k++) begin
            idle(1'b1, 1'b0);
            chk("im_wait", 64'(last_ctrl), 64'(7'b0111001));
        end
        idle(1'b0, 1'b0);
        chk("im_rel", 64'(last_ctrl), 64'(7'b1111011));
        chk("im_tgt", 64'(last_red), 64'(32'h200));
        idle(1'b0, 1'b0);
        chk("im_run", 64'(last_ctrl), 64'(7'b1110000));

        // D-miss freezes a WAIT_I release
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h480, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk("dm_c1", 64'(last_ctrl), 64'(7'b0000001));
        for (int k = 0; k < 3; k++) begin
            idle(1'b0, 1'b1);
            chk("dm_frz", 64'(last_ctrl), 64'(7'b0000001));
        end
        idle(1'b0, 1'b0);
        chk("dm_rel", 64'(last_ctrl), 64'(7'b1111011));
        chk("dm_tgt", 64'(last_red), 64'(32'h480));

        // Reset in WAIT_I drops the pending redirect
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        do_reset();
        chk("rw_ctrl", 64'(last_ctrl), 64'(7'b0000000));
        chk("rw_cnt", 64'(stall_cnt), 64'(16'd0));
        idle(1'b0, 1'b0);
        chk("rw_run", 64'(last_ctrl), 64'(7'b1110000));
        chk("rw_red", 64'(last_red), 64'(32'h0));

        // Saturation of the 4-bit counters
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat4", 64'(a_stall_cnt), 64'(4'd15));
        chk("sat16", 64'(stall_cnt), 64'(16'd20));

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), $urandom(),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
